id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
// ID/EX pipeline register of the pipelined RV64 core, directly downstream of the register file.
// Captures decoded instructions with their source operands and resolves RAW hazards.
// Operand sources are EX/MEM forwarding, then MEM/WB forwarding, then the register-file read ports.
// Detects load-use hazards and inserts one bubble. Supports downstream backpressure and branch flush.
// PARAMETERS
// XLEN    64  datapath width
// CTRL_W  16  opaque decoded-control bundle width, passed through unchanged
// CNT_W   32  width of the load-use stall counter
// PORTS
// clk           in   1       clock, rising edge
// reset         in   1       synchronous, active-high
// id_valid      in   1       decode presents an instruction
// id_ready      out  1       stage accepts the instruction this cycle
// id_rs1/id_rs2 in   5       source register indices
// id_use_rs1/2  in   1       instruction actually reads rs1 / rs2
// id_rd         in   5       destination index
// id_reg_write  in   1       instruction writes rd
// id_mem_read   in   1       instruction is a load
// id_pc/id_imm  in   XLEN    PC and sign-extended immediate
// id_ctrl       in   CTRL_W  decoded control bundle
// rf_rdata1/2   in   XLEN    register-file read data for id_rs1 / id_rs2 (x0 reads 0)
// exm_reg_write, exm_rd, exm_result   in 1/5/XLEN   EX/MEM writer; result is final, load data included
// wb_reg_write, wb_rd, wb_data        in 1/5/XLEN   MEM/WB writer
// flush         in   1       squash the stage (branch redirect from EX)
// ex_ready      in   1       EX accepts the output register contents
// ex_valid      out  1       output register holds a live instruction
// ex_rs1_val/ex_rs2_val  out XLEN  resolved operands
// ex_rd, ex_reg_write, ex_mem_read, ex_pc, ex_imm, ex_ctrl   out   registered copies of id_* fields
// stall_cnt     out  CNT_W   count of load-use bubbles inserted; saturates at all-ones
// BEHAVIOUR
// - Reset: all outputs and registers go to 0 (ex_valid=0, stall_cnt=0). Reset wins over every other input.
// - Operand select, combinational, per source s:
//   - s==0 gives 0.
//   - Else, if exm_reg_write && exm_rd==s, use exm_result.
//   - Else, if wb_reg_write && wb_rd==s, use wb_data.
//   - Else, use rf_rdata.
//   - The MEM/WB path is mandatory: the register file does not bypass same-cycle writes.
// - load_use = ex_valid && ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
// - adv = ex_ready || !ex_valid; this is when the output register may change.
// - id_ready = adv && !load_use && !flush.
// - On a rising edge, when adv or flush:
//   - ex_valid <= id_valid && id_ready.
//   - Payload and resolved operands load only when id_valid && id_ready; otherwise they hold.
// - Load-use: id_ready=0. If adv, a bubble enters (ex_valid=0) and stall_cnt increments once.
//   The next cycle the load is in EX/MEM and the instruction is accepted with the forwarded exm_result.
// - Backpressure (ex_valid && !ex_ready, no flush): all outputs hold. Upstream EX/MEM and WB are also frozen.
// - flush: at the next edge ex_valid=0 and the ID instruction is dropped; flush beats load_use and backpressure.
// - Latency: 1 cycle from ID handshake to ex_valid. Throughput is 1/cycle when there is no hazard.
// - id_ready is combinational on ex_ready, flush and ID fields; it must have no combinational path from ex_* outputs other than via registers.
// TESTING
// 1. Reset high for 2 cycles with id_valid=1 -> ex_valid=0, all ex_* and stall_cnt =0, id_ready=0 during reset edge.
// 2. exm writes x5=0xAA, wb writes x5=0xBB, rf=0xCC; rs1=5 -> ex_rs1_val=0xAA. exm off -> 0xBB. Both off -> 0xCC.
// 3. wb writes x0=0x55, rs2=0 -> ex_rs2_val=0. id_use_rs1=0 with a load-hazard match -> no stall.
// 4. Load to x7 in EX, then an add reading x7 -> one bubble, stall_cnt=1. Next cycle add captured with exm_result=0x1234.
// 5. ex_valid=1, ex_ready=0 for 3 cycles -> outputs stable, id_ready=0. Raise ex_ready -> next instruction advances in 1 cycle.
// 6. flush coincident with load_use and with ex_ready=0 -> ex_valid=0 next cycle, stall_cnt unchanged. stall_cnt preset at max -> stays max.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register for the RV64 core: resolves source operands through
// EX/MEM and MEM/WB forwarding, inserts load-use bubbles, honours backpressure and flush.
module id_ex_operand_stage #(
   parameter int XLEN   = 64,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [4:0]        id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [XLEN-1:0]   rf_rdata1,
   input  logic [XLEN-1:0]   rf_rdata2,
   input  logic              exm_reg_write,
   input  logic [4:0]        exm_rd,
   input  logic [XLEN-1:0]   exm_result,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_rs1_val,
   output logic [XLEN-1:0]   ex_rs2_val,
   output logic [4:0]        ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic            adv;
   logic            load_use;
   logic            accept;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   // EX/MEM is the younger writer, so it wins over MEM/WB; the register file
   // does not bypass same-cycle writes, so MEM/WB forwarding is required.
   function automatic logic [XLEN-1:0] resolve(input logic [4:0]      src,
                                                input logic [XLEN-1:0] rf_val,
                                                input logic            e_we,
                                                input logic [4:0]      e_rd,
                                                input logic [XLEN-1:0] e_val,
                                                input logic            w_we,
                                                input logic [4:0]      w_rd,
                                                input logic [XLEN-1:0] w_val);
      logic [XLEN-1:0] r;
      if (src == 5'd0)                  r = '0;
      else if (e_we && (e_rd == src))   r = e_val;
      else if (w_we && (w_rd == src))   r = w_val;
      else                              r = rf_val;
      return r;
   endfunction

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      rs1_val  = '0;
      rs2_val  = '0;
      load_use = 1'b0;
      rs1_val  = resolve(id_rs1, rf_rdata1, exm_reg_write, exm_rd, exm_result,
                         wb_reg_write, wb_rd, wb_data);
      rs2_val  = resolve(id_rs2, rf_rdata2, exm_reg_write, exm_rd, exm_result,
                         wb_reg_write, wb_rd, wb_data);
      // Only registered ex_* state feeds the hazard check, keeping id_ready free of loops.
      load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
   end

   assign adv      = ex_ready || !ex_valid;
   assign id_ready = !reset && adv && !load_use && !flush;
   assign accept   = id_valid && id_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid     <= 1'b0;
         ex_rs1_val   <= '0;
         ex_rs2_val   <= '0;
         ex_rd        <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_pc        <= '0;
         ex_imm       <= '0;
         ex_ctrl      <= '0;
         stall_cnt    <= '0;
      end else begin
         if (adv || flush) begin
            ex_valid <= accept;
            if (accept) begin
               ex_rs1_val   <= rs1_val;
               ex_rs2_val   <= rs2_val;
               ex_rd        <= id_rd;
               ex_reg_write <= id_reg_write;
               ex_mem_read  <= id_mem_read;
               ex_pc        <= id_pc;
               ex_imm       <= id_imm;
               ex_ctrl      <= id_ctrl;
            end
         end
         // A bubble is counted only when it actually enters; flush takes precedence.
         if (id_valid && load_use && adv && !flush && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
